write_logic: RTL and testbench

- Write-side controller for the FIFO memory. It is the counterpart of the FIFO read controller.
- Generates the memory write strobe (push) and the write pointer.
- Owns the occupancy counter and drives the status flags: fifo_full, fifo_empty, almost_full, almost_empty. The read controller consumes fifo_empty.
- Latches sticky overflow and underflow errors for the FIFO top level.

---
 rtl/write_logic_pkg.sv | 26 ++
 rtl/write_logic_status_flags.sv | 24 ++
 rtl/write_logic.sv | 73 +++++++
 tb/tb_write_logic.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/write_logic_pkg.sv
// Shared FIFO definitions: default geometry and the push/pop qualification rule
// used by both the write and read controllers.
package write_logic_pkg;

  localparam int unsigned FIFO_MEM_SIZE  = 4;
  localparam int unsigned FIFO_WORD_SIZE = 6;
  localparam int unsigned FIFO_PTR_L     = 3;

  // Occupancy update selector, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_DEC  = 2'b01,
    OCC_INC  = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_e;

  // A request is honoured unless its side is blocked (full for push, empty
  // for pop); the opposite request in the same cycle lifts the block.
  function automatic logic qualify_req(input logic reset_l,
                                       input logic req,
                                       input logic blocked,
                                       input logic bypass);
    return reset_l & req & (~blocked | bypass);
  endfunction

endpackage

// File: rtl/write_logic_status_flags.sv
// Combinational decode of FIFO occupancy into full/empty and threshold flags.
module fifo_status_flags
  import write_logic_pkg::*;
#(
  parameter int unsigned PTR_L    = FIFO_PTR_L,
  parameter int unsigned MEM_SIZE = FIFO_MEM_SIZE,
  parameter int unsigned AF_TH    = 3,
  parameter int unsigned AE_TH    = 1
) (
  input  logic [PTR_L-1:0] occupancy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty
);

  always_comb begin
    fifo_full    = (occupancy == PTR_L'(MEM_SIZE));
    fifo_empty   = (occupancy == '0);
    almost_full  = (occupancy >= PTR_L'(AF_TH));
    almost_empty = (occupancy <= PTR_L'(AE_TH));
  end

endmodule

// File: rtl/write_logic.sv
// FIFO write-side controller: write strobe and pointer, occupancy counter,
// status flags and sticky overflow/underflow errors.
module write_logic
  import write_logic_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = FIFO_MEM_SIZE,
  parameter int unsigned WORD_SIZE = FIFO_WORD_SIZE,
  parameter int unsigned PTR_L     = FIFO_PTR_L,
  parameter int unsigned AF_TH     = 3,
  parameter int unsigned AE_TH     = 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             fifo_wr,
  input  logic             fifo_rd,
  output logic [PTR_L-1:0] wr_ptr,
  output logic             push,
  output logic [PTR_L-1:0] occupancy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  if (MEM_SIZE >= (1 << PTR_L) || WORD_SIZE == 0) begin : g_bad_cfg
    $error("write_logic: MEM_SIZE must fit below 2**PTR_L and WORD_SIZE must be nonzero");
  end

  logic    pop_i;
  occ_op_e occ_op;

  always_comb begin
    push   = qualify_req(reset_L, fifo_wr, fifo_full, fifo_rd);
    pop_i  = qualify_req(reset_L, fifo_rd, fifo_empty, fifo_wr);
    occ_op = occ_op_e'({push, pop_i});
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_L'(MEM_SIZE - 1)) ? '0 : wr_ptr + PTR_L'(1);
      end
      case (occ_op)
        OCC_INC: occupancy <= occupancy + PTR_L'(1);
        OCC_DEC: occupancy <= occupancy - PTR_L'(1);
        default: occupancy <= occupancy;
      endcase
      if (fifo_wr & fifo_full & ~fifo_rd) overflow <= 1'b1;
      if (fifo_rd & fifo_empty & ~fifo_wr) underflow <= 1'b1;
    end
  end

  fifo_status_flags #(
    .PTR_L    (PTR_L),
    .MEM_SIZE (MEM_SIZE),
    .AF_TH    (AF_TH),
    .AE_TH    (AE_TH)
  ) u_flags (
    .occupancy    (occupancy),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

endmodule

// File: tb/tb_write_logic.sv
// Directed table-driven bench for write_logic (MEM_SIZE=4, AF_TH=3, AE_TH=1).
module tb_write_logic;

  logic       clk = 1'b0;
  logic       reset_L, fifo_wr, fifo_rd;
  logic [2:0] wr_ptr, occupancy;
  logic       push, fifo_full, fifo_empty, almost_full, almost_empty;
  logic       overflow, underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  write_logic #(
    .MEM_SIZE  (4),
    .WORD_SIZE (6),
    .PTR_L     (3),
    .AF_TH     (3),
    .AE_TH     (1)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .fifo_wr      (fifo_wr),
    .fifo_rd      (fifo_rd),
    .wr_ptr       (wr_ptr),
    .push         (push),
    .occupancy    (occupancy),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Each row: inputs for this cycle, then the expected push and the state
  // visible before the row's edge. flags = {full, empty, almost_full, almost_empty}.
  typedef struct {
    logic       rst_l;
    logic       wr;
    logic       rd;
    logic       e_push;
    logic [2:0] e_ptr;
    logic [2:0] e_occ;
    logic [3:0] e_flags;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic d,
                              input logic p, input int ptr, input int occ,
                              input logic [3:0] fl, input logic o, input logic u);
    vec_t v;
    v.rst_l = r; v.wr = w; v.rd = d; v.e_push = p;
    v.e_ptr = 3'(ptr); v.e_occ = 3'(occ); v.e_flags = fl;
    v.e_ovf = o; v.e_unf = u;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(0,1,0, 0,0,0,4'b0101,0,0);
    vecs[1]  = mk(1,1,0, 1,0,0,4'b0101,0,0);
    vecs[2]  = mk(1,1,0, 1,1,1,4'b0001,0,0);
    vecs[3]  = mk(1,1,0, 1,2,2,4'b0000,0,0);
    vecs[4]  = mk(1,1,0, 1,3,3,4'b0010,0,0);
    vecs[5]  = mk(1,1,0, 0,0,4,4'b1010,0,0);
    vecs[6]  = mk(1,1,1, 1,0,4,4'b1010,1,0);
    vecs[7]  = mk(1,1,1, 1,1,4,4'b1010,1,0);
    vecs[8]  = mk(1,1,1, 1,2,4,4'b1010,1,0);
    vecs[9]  = mk(1,0,1, 0,3,4,4'b1010,1,0);
    vecs[10] = mk(1,0,1, 0,3,3,4'b0010,1,0);
    vecs[11] = mk(1,0,1, 0,3,2,4'b0000,1,0);
    vecs[12] = mk(1,0,1, 0,3,1,4'b0001,1,0);
    vecs[13] = mk(1,1,1, 1,3,0,4'b0101,1,0);
    vecs[14] = mk(1,0,1, 0,0,0,4'b0101,1,0);
    vecs[15] = mk(1,0,0, 0,0,0,4'b0101,1,1);
    vecs[16] = mk(1,0,0, 0,0,0,4'b0101,1,1);
    vecs[17] = mk(0,0,0, 0,0,0,4'b0101,1,1);
    vecs[18] = mk(1,1,0, 1,0,0,4'b0101,0,0);
    vecs[19] = mk(1,1,0, 1,1,1,4'b0001,0,0);
    vecs[20] = mk(1,1,0, 1,2,2,4'b0000,0,0);
    vecs[21] = mk(0,1,0, 0,3,3,4'b0010,0,0);
    vecs[22] = mk(1,1,0, 1,0,0,4'b0101,0,0);
    vecs[23] = mk(1,0,0, 0,1,1,4'b0001,0,0);

    reset_L = 1'b0; fifo_wr = 1'b1; fifo_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      reset_L = vecs[i].rst_l;
      fifo_wr = vecs[i].wr;
      fifo_rd = vecs[i].rd;
      #2;
      check($sformatf("v%0d.push", i), push, vecs[i].e_push);
      check($sformatf("v%0d.wr_ptr", i), wr_ptr, vecs[i].e_ptr);
      check($sformatf("v%0d.occupancy", i), occupancy, vecs[i].e_occ);
      check($sformatf("v%0d.flags", i),
            {fifo_full, fifo_empty, almost_full, almost_empty}, vecs[i].e_flags);
      check($sformatf("v%0d.overflow", i), overflow, vecs[i].e_ovf);
      check($sformatf("v%0d.underflow", i), underflow, vecs[i].e_unf);
      @(posedge clk);
      #1;
    end

    // Fill, then read+write while full across the pointer wrap.
    reset_L = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0;
    @(posedge clk); #1;
    reset_L = 1'b1; fifo_wr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("fill%0d.occupancy", i), occupancy, i);
      check($sformatf("fill%0d.wr_ptr", i), wr_ptr, i % 4);
    end
    check("fill.full", fifo_full, 1);
    fifo_rd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("rw%0d.push", i), push, 1);
      @(posedge clk); #1;
      check($sformatf("rw%0d.wr_ptr", i), wr_ptr, i % 4);
      check($sformatf("rw%0d.occupancy", i), occupancy, 4);
      check($sformatf("rw%0d.overflow", i), overflow, 0);
    end

    // Write while full with reset asserted: reset wins, no overflow recorded.
    reset_L = 1'b0; fifo_rd = 1'b0;
    #1;
    check("rstfull.push", push, 0);
    @(posedge clk); #1;
    check("rstfull.overflow", overflow, 0);
    check("rstfull.occupancy", occupancy, 0);
    check("rstfull.full", fifo_full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
